// File: rtl/parking_exit_controller.sv
// Exit-side gate controller and lot occupancy tracker.
// Cars are counted in on car_entered pulses and counted out only when a paid
// car is confirmed past the exit gate. All outputs are registered.
module parking_exit_controller #(
    parameter int unsigned CAPACITY         = 8,
    parameter int unsigned CNT_W            = 4,
    parameter int unsigned GATE_OPEN_CYCLES = 50,
    parameter int unsigned PAY_TIMEOUT      = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_entered,
    input  logic             exit_sensor,
    input  logic             exit_paid,
    input  logic             exit_clear_sensor,
    output logic             exit_gate_open,
    output logic             green_light,
    output logic             red_light,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             error_flag,
    output logic [6:0]       hex_free
);

    localparam int unsigned TMR_MAX = (PAY_TIMEOUT > GATE_OPEN_CYCLES) ? PAY_TIMEOUT : GATE_OPEN_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OPEN  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_next;
    logic [CNT_W-1:0]   occ_next;
    logic [CNT_W-1:0]   free_next;
    logic               dec;
    logic               err_set;

    // Active-low {g,f,e,d,c,b,a} pattern for a single decimal digit; blank otherwise.
    function automatic logic [6:0] seg7(input logic [CNT_W-1:0] v);
        logic [6:0] s;
        case (v)
            CNT_W'(0): s = 7'h40;
            CNT_W'(1): s = 7'h79;
            CNT_W'(2): s = 7'h24;
            CNT_W'(3): s = 7'h30;
            CNT_W'(4): s = 7'h19;
            CNT_W'(5): s = 7'h12;
            CNT_W'(6): s = 7'h02;
            CNT_W'(7): s = 7'h78;
            CNT_W'(8): s = 7'h00;
            CNT_W'(9): s = 7'h10;
            default:   s = 7'h7F;
        endcase
        return s;
    endfunction

    // Next-state, wait timer and occupancy update.
    always_comb begin
        next_state = state;
        dec        = 1'b0;
        err_set    = 1'b0;
        occ_next   = occupancy;
        timer_next = '0;

        case (state)
            S_IDLE: begin
                if (exit_sensor) begin
                    if (occupancy != '0) begin
                        next_state = S_CHECK;
                    end else begin
                        next_state = S_FAULT;
                        err_set    = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (exit_paid) begin
                    next_state = S_OPEN;
                end else if (!exit_sensor) begin
                    next_state = S_IDLE;
                end else if (timer == TMR_W'(PAY_TIMEOUT - 1)) begin
                    next_state = S_IDLE;
                end
            end
            S_OPEN: begin
                if (exit_clear_sensor) begin
                    dec        = 1'b1;
                    next_state = S_IDLE;
                end else if (timer == TMR_W'(GATE_OPEN_CYCLES - 1)) begin
                    next_state = S_IDLE;
                end
            end
            S_FAULT: begin
                if (!exit_sensor) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase

        // Timer only runs while waiting in CHECK/OPEN; any state change restarts it.
        if (next_state == state && (state == S_CHECK || state == S_OPEN)) begin
            timer_next = timer + TMR_W'(1);
        end

        // Simultaneous entry and exit cancel out, even when the lot is full.
        if (car_entered && !dec) begin
            if (occupancy == CNT_W'(CAPACITY)) begin
                err_set = 1'b1;
            end else begin
                occ_next = occupancy + CNT_W'(1);
            end
        end else if (dec && !car_entered) begin
            if (occupancy == '0) begin
                err_set = 1'b1;
            end else begin
                occ_next = occupancy - CNT_W'(1);
            end
        end

        free_next = CNT_W'(CAPACITY) - occ_next;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            timer          <= '0;
            occupancy      <= '0;
            exit_gate_open <= 1'b0;
            green_light    <= 1'b0;
            red_light      <= 1'b0;
            error_flag     <= 1'b0;
            lot_full       <= 1'b0;
            lot_empty      <= 1'b1;
            hex_free       <= seg7(CNT_W'(CAPACITY));
        end else begin
            state          <= next_state;
            timer          <= timer_next;
            occupancy      <= occ_next;
            exit_gate_open <= (next_state == S_OPEN);
            green_light    <= (next_state == S_OPEN);
            red_light      <= (next_state == S_CHECK) || (next_state == S_FAULT);
            error_flag     <= error_flag | err_set;
            lot_full       <= (occ_next == CNT_W'(CAPACITY));
            lot_empty      <= (occ_next == '0);
            hex_free       <= seg7(free_next);
        end
    end

endmodule

// File: tb/tb_parking_exit_controller.sv
// Bench for parking_exit_controller: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the lot.
module tb_parking_exit_controller;

    localparam int unsigned CAPACITY         = 8;
    localparam int unsigned CNT_W            = 4;
    localparam int unsigned GATE_OPEN_CYCLES = 50;
    localparam int unsigned PAY_TIMEOUT      = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic             car_entered;
    logic             exit_sensor;
    logic             exit_paid;
    logic             exit_clear_sensor;
    logic             exit_gate_open;
    logic             green_light;
    logic             red_light;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full;
    logic             lot_empty;
    logic             error_flag;
    logic [6:0]       hex_free;

    int total = 0;
    int bad   = 0;

    parking_exit_controller #(
        .CAPACITY        (CAPACITY),
        .CNT_W           (CNT_W),
        .GATE_OPEN_CYCLES(GATE_OPEN_CYCLES),
        .PAY_TIMEOUT     (PAY_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .car_entered      (car_entered),
        .exit_sensor      (exit_sensor),
        .exit_paid        (exit_paid),
        .exit_clear_sensor(exit_clear_sensor),
        .exit_gate_open   (exit_gate_open),
        .green_light      (green_light),
        .red_light        (red_light),
        .occupancy        (occupancy),
        .lot_full         (lot_full),
        .lot_empty        (lot_empty),
        .error_flag       (error_flag),
        .hex_free         (hex_free)
    );

    always #5 clk = ~clk;

    // Digit patterns for the free-space display, index = number of free spaces.
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: what the exit lane is doing and how long it has been doing it.
    typedef enum int {P_IDLE, P_AWAIT_PAY, P_GATE_UP, P_PHANTOM} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_wait  = 0;
    int     m_cars  = 0;
    bit     m_err   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit r, input bit ce, input bit es, input bit ep, input bit ecs);
        phase_t nxt;
        bit     passed;
        if (r) begin
            m_phase = P_IDLE;
            m_wait  = 0;
            m_cars  = 0;
            m_err   = 1'b0;
            return;
        end
        nxt    = m_phase;
        passed = 1'b0;
        case (m_phase)
            P_IDLE: if (es) begin
                if (m_cars > 0) nxt = P_AWAIT_PAY;
                else begin nxt = P_PHANTOM; m_err = 1'b1; end
            end
            P_AWAIT_PAY: begin
                if (ep) nxt = P_GATE_UP;
                else if (!es) nxt = P_IDLE;
                else if (m_wait + 1 >= PAY_TIMEOUT) nxt = P_IDLE;
            end
            P_GATE_UP: begin
                if (ecs) begin passed = 1'b1; nxt = P_IDLE; end
                else if (m_wait + 1 >= GATE_OPEN_CYCLES) nxt = P_IDLE;
            end
            P_PHANTOM: if (!es) nxt = P_IDLE;
            default: nxt = P_IDLE;
        endcase
        m_wait  = (nxt == m_phase) ? m_wait + 1 : 0;
        m_phase = nxt;
        if (ce && !passed) begin
            if (m_cars == CAPACITY) m_err = 1'b1;
            else m_cars++;
        end else if (passed && !ce) begin
            if (m_cars == 0) m_err = 1'b1;
            else m_cars--;
        end
    endtask

    // Drive one cycle of inputs, then compare every output against the model.
    task automatic cyc(input bit r, input bit ce, input bit es, input bit ep, input bit ecs);
        @(negedge clk);
        reset             = r;
        car_entered       = ce;
        exit_sensor       = es;
        exit_paid         = ep;
        exit_clear_sensor = ecs;
        model_step(r, ce, es, ep, ecs);
        @(posedge clk);
        #1;
        check_eq("gate",  32'(exit_gate_open), 32'(m_phase == P_GATE_UP));
        check_eq("green", 32'(green_light),    32'(m_phase == P_GATE_UP));
        check_eq("red",   32'(red_light),      32'(m_phase == P_AWAIT_PAY || m_phase == P_PHANTOM));
        check_eq("occ",   32'(occupancy),      32'(m_cars));
        check_eq("full",  32'(lot_full),       32'(m_cars == CAPACITY));
        check_eq("empty", 32'(lot_empty),      32'(m_cars == 0));
        check_eq("err",   32'(error_flag),     32'(m_err));
        check_eq("hex",   32'(hex_free),       32'(seg_tab[CAPACITY - m_cars]));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int ce_div;
        bit es;
        reset = 1'b1; car_entered = 1'b0; exit_sensor = 1'b0;
        exit_paid = 1'b0; exit_clear_sensor = 1'b0;

        // Reset state.
        do_reset();
        check_eq("rst_hex", 32'(hex_free), 32'h00);
        check_eq("rst_occ", 32'(occupancy), 32'd0);

        // Three cars in, one paid exit.
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("t2_red", 32'(red_light), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("t2_gate", 32'(exit_gate_open), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("t2_occ", 32'(occupancy), 32'd2);
        check_eq("t2_hex", 32'(hex_free), 32'h02);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Payment timeout: car waits without paying.
        repeat (PAY_TIMEOUT + 2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t3_occ", 32'(occupancy), 32'd2);

        // Fill the lot, coincident entry/exit at full, then overflow.
        do_reset();
        repeat (CAPACITY) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t4_full", 32'(lot_full), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("t4_coin_occ", 32'(occupancy), 32'(CAPACITY));
        check_eq("t4_coin_err", 32'(error_flag), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t4_ovf_err", 32'(error_flag), 32'd1);

        // Phantom exit on an empty lot.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t5_red", 32'(red_light), 32'd1);
        check_eq("t5_err", 32'(error_flag), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t5_idle_red", 32'(red_light), 32'd0);

        // Gate timeout with no pass, then reset while the gate is open.
        do_reset();
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (GATE_OPEN_CYCLES + 1) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_occ", 32'(occupancy), 32'd2);
        check_eq("t6_gate", 32'(exit_gate_open), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t6_open", 32'(exit_gate_open), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_rst_gate", 32'(exit_gate_open), 32'd0);
        check_eq("t6_rst_occ", 32'(occupancy), 32'd0);

        // Random traffic with epochs of busy and quiet entry rates.
        es = 1'b0;
        ce_div = 4;
        for (int i = 0; i < 15000; i++) begin
            if (i % 500 == 0) ce_div = ($urandom_range(0, 1) == 0) ? 4 : 40;
            if ($urandom_range(0, 63) == 0) es = ~es;
            cyc($urandom_range(0, 2999) == 0,
                $urandom_range(0, ce_div - 1) == 0,
                es,
                $urandom_range(0, 99) == 0,
                $urandom_range(0, 29) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
